rab_xlate_arb: RTL

Parametrised successor to the per-port translation path of the RAB core. One translation engine serves `N_REQ` requestors through a round-robin arbiter and a registered range-table lookup. It adds a permission-checked, wrap-safe burst range check and an optional miss-history FIFO. The block sits between the AXI slave-side address channels and the master-side forwarding logic, with one instance per RAB port.

---
 rtl/rab_xlate_arb.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rab_xlate_arb.sv
// Round-robin arbitrated range-table translation engine for one RAB port.
// Optional miss-history FIFO is built when RAB_MISS_FIFO_EN is defined.

module rab_xlate_slice (
  input  logic [31:0] start_addr,
  input  logic [31:0] end_addr,
  input  logic [31:0] offset,
  input  logic [31:0] flags,
  input  logic [31:0] addr,
  input  logic [31:0] max_addr,
  input  logic        wrap,
  input  logic        is_write,
  output logic        hit,
  output logic        prot,
  output logic [31:0] xaddr
);
  logic unused_flags;
  assign unused_flags = ^flags[31:3];

  assign hit   = flags[0] & (start_addr <= addr) & (max_addr <= end_addr) & ~wrap;
  assign prot  = hit & ~(is_write ? flags[2] : flags[1]);
  assign xaddr = addr - start_addr + offset;
endmodule

module rab_xlate_arb #(
  parameter  int N_REQ           = 2,
  parameter  int RAB_ENTRIES     = 16,
  parameter  int ID_W            = 8,
  parameter  int MISS_FIFO_DEPTH = 4,
  localparam int GNT_W           = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                                s_axi_aclk,
  input  logic                                s_axi_areset,
  input  logic [4*RAB_ENTRIES-1:0][31:0]      cfg_regs,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][31:0]              req_addr,
  input  logic [N_REQ-1:0][ID_W-1:0]          req_id,
  input  logic [N_REQ-1:0][7:0]               req_len,
  input  logic [N_REQ-1:0][2:0]               req_size,
  input  logic [N_REQ-1:0]                    req_type,
  input  logic [N_REQ-1:0]                    req_sent,
  output logic [N_REQ-1:0]                    req_accept,
  output logic [N_REQ-1:0]                    req_drop,
  output logic [31:0]                         out_addr,
  output logic                                int_miss,
  output logic                                int_prot,
  output logic                                int_multi,
  input  logic                                miss_pop,
  output logic                                miss_valid,
  output logic [31:0]                         miss_addr,
  output logic [GNT_W+ID_W-1:0]               miss_id,
  output logic                                int_mhr_full
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WAIT_SENT} state_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic [7:0]      len;
    logic [2:0]      size;
    logic            wr;
  } req_t;

  state_t             state;
  req_t               req_q;
  logic [GNT_W-1:0]   gnt_q, rr_ptr;

  // ---------------- round-robin arbiter ----------------
  // Rotate valids so rr_ptr sits at bit 0, then find the first set bit.
  logic [N_REQ-1:0]            rv_rot;
  logic [N_REQ:0]              rv_seen;
  logic [N_REQ:0][GNT_W-1:0]   off_acc;
  logic [GNT_W:0]              gnt_sum;
  logic [GNT_W-1:0]            gnt_idx, rr_nxt;
  logic                        gnt_found;
  logic [N_REQ-1:0]            gnt_oh;

  assign rv_rot     = N_REQ'({req_valid, req_valid} >> rr_ptr);
  assign rv_seen[0] = 1'b0;
  assign off_acc[0] = '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_arb
    assign rv_seen[i+1] = rv_seen[i] | rv_rot[i];
    assign off_acc[i+1] = off_acc[i] | ((rv_rot[i] & ~rv_seen[i]) ? GNT_W'(i) : '0);
  end

  assign gnt_found = rv_seen[N_REQ];
  assign gnt_sum   = {1'b0, rr_ptr} + {1'b0, off_acc[N_REQ]};
  assign gnt_idx   = (gnt_sum >= (GNT_W+1)'(N_REQ)) ? GNT_W'(gnt_sum - (GNT_W+1)'(N_REQ))
                                                    : gnt_sum[GNT_W-1:0];
  assign rr_nxt    = (gnt_idx == GNT_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_oh    = N_REQ'(1) << gnt_q;

  // ---------------- range lookup ----------------
  // 33-bit end-of-burst so a burst crossing 4 GiB is visible as wrap.
  logic [32:0]                    span, max_addr;
  logic [RAB_ENTRIES-1:0]         hit, prot;
  logic [RAB_ENTRIES-1:0][31:0]   xaddr;
  logic [RAB_ENTRIES:0]           hit_seen;
  logic [RAB_ENTRIES:0][31:0]     xa_acc;
  logic                           any_hit, multi_hit, sel_prot;

  assign span        = (33'(req_q.len) + 33'd1) << req_q.size;
  assign max_addr    = {1'b0, req_q.addr} + span - 33'd1;
  assign hit_seen[0] = 1'b0;
  assign xa_acc[0]   = '0;

  for (genvar k = 0; k < RAB_ENTRIES; k++) begin : g_slice
    rab_xlate_slice u_slice (
      .start_addr (cfg_regs[4*k]),
      .end_addr   (cfg_regs[4*k+1]),
      .offset     (cfg_regs[4*k+2]),
      .flags      (cfg_regs[4*k+3]),
      .addr       (req_q.addr),
      .max_addr   (max_addr[31:0]),
      .wrap       (max_addr[32]),
      .is_write   (req_q.wr),
      .hit        (hit[k]),
      .prot       (prot[k]),
      .xaddr      (xaddr[k])
    );
    assign hit_seen[k+1] = hit_seen[k] | hit[k];
    assign xa_acc[k+1]   = xa_acc[k] | ({32{hit[k] & ~hit_seen[k]}} & xaddr[k]);
  end

  assign any_hit   = hit_seen[RAB_ENTRIES];
  assign multi_hit = |(hit & hit_seen[RAB_ENTRIES-1:0]);
  assign sel_prot  = |(prot & hit & ~hit_seen[RAB_ENTRIES-1:0]);

  // ---------------- control FSM ----------------
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      req_q      <= '0;
      out_addr   <= '0;
      req_accept <= '0;
      req_drop   <= '0;
      int_miss   <= 1'b0;
      int_prot   <= 1'b0;
      int_multi  <= 1'b0;
    end else begin
      req_accept <= '0;
      req_drop   <= '0;
      int_miss   <= 1'b0;
      int_prot   <= 1'b0;
      int_multi  <= 1'b0;
      case (state)
        IDLE: if (gnt_found) begin
          gnt_q  <= gnt_idx;
          rr_ptr <= rr_nxt;
          req_q  <= '{addr: req_addr[gnt_idx], id: req_id[gnt_idx], len: req_len[gnt_idx],
                      size: req_size[gnt_idx], wr: req_type[gnt_idx]};
          state  <= LOOKUP;
        end
        LOOKUP: begin
          if (any_hit) out_addr <= xa_acc[RAB_ENTRIES];
          if (any_hit && !multi_hit && !sel_prot) req_accept <= gnt_oh;
          else                                    req_drop   <= gnt_oh;
          int_miss  <= ~any_hit;
          int_multi <= multi_hit;
          int_prot  <= any_hit & ~multi_hit & sel_prot;
          state     <= RESP;
        end
        RESP:      state <= (|req_accept) ? WAIT_SENT : IDLE;
        WAIT_SENT: if (req_sent[gnt_q]) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // ---------------- miss history FIFO ----------------
`ifdef RAB_MISS_FIFO_EN
  localparam int AW = $clog2(MISS_FIFO_DEPTH);

  typedef struct packed {
    logic [GNT_W-1:0] gnt;
    logic [ID_W-1:0]  id;
    logic [31:0]      addr;
  } miss_t;

  miss_t          mem [MISS_FIFO_DEPTH];
  miss_t          head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt;
  logic           empty, full, push, pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(MISS_FIFO_DEPTH));
  assign pop   = miss_pop & ~empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push  = (state == RESP) & int_miss & (~full | pop);

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push) mem[wr_ptr] <= '{gnt: gnt_q, id: req_q.id, addr: req_q.addr};
  end

  assign head         = mem[rd_ptr];
  assign miss_valid   = ~empty;
  assign int_mhr_full = full;
  assign miss_addr    = empty ? '0 : head.addr;
  assign miss_id      = empty ? '0 : {head.gnt, head.id};
`else
  logic unused_fifo;
  assign unused_fifo  = miss_pop ^ (^req_q.id);
  assign miss_valid   = 1'b0;
  assign int_mhr_full = 1'b0;
  assign miss_addr    = '0;
  assign miss_id      = '0;
`endif

endmodule
